// File: rtl/bt656_pkg.sv
// BT.656 definitions shared by the TRS inserter and the parser: TRS words, blanking
// levels, the XYZ protection-bit encoder and the inserter FSM states.
package bt656_pkg;

   localparam int unsigned TrsLen = 4;

   localparam logic [9:0] TrsPreamble0 = 10'h3FF;
   localparam logic [9:0] TrsPreamble1 = 10'h000;
   localparam logic [9:0] BlankY       = 10'h040;
   localparam logic [9:0] BlankC       = 10'h200;
   localparam logic [9:0] ClipLo       = 10'h004;
   localparam logic [9:0] ClipHi       = 10'h3FB;

   typedef enum logic [0:0] {
      StPass,
      StTrs
   } trs_state_e;

   // 10-bit XYZ word; 8-bit users take the top eight bits.
   function automatic logic [9:0] xyz(input logic f, input logic v, input logic h);
      return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
   endfunction

endpackage

// File: rtl/bt656_trs_inserter_if.sv
// Video sample bus between the timing generator (master) and the TRS inserter (slave).
interface bt656_trs_inserter_if #(
   parameter int unsigned DATA_WIDTH = 10
);

   logic                  ce;
   logic [DATA_WIDTH-1:0] din;
   logic                  h_in;
   logic                  v_in;
   logic                  f_in;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  trs_err;

   modport master (
      output ce, din, h_in, v_in, f_in,
      input  dout, dout_valid, trs_err
   );

   modport slave (
      input  ce, din, h_in, v_in, f_in,
      output dout, dout_valid, trs_err
   );

endinterface

// File: rtl/bt656_sample_delay.sv
// Four-stage ce-gated delay line carrying each sample with its H/V/F flags and EAV marker.
// Reset fills it with blanking (H=1, V=1) so no H edge is seen after reset.
module bt656_sample_delay
   import bt656_pkg::*;
#(
   parameter int unsigned          DataWidth = 10,
   parameter logic [DataWidth-1:0] FillData  = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 h_i,
   input  logic                 v_i,
   input  logic                 f_i,
   input  logic                 eav_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 h_o,
   output logic                 v_o,
   output logic                 f_o,
   output logic                 eav_o,
   output logic                 h_last_o
);

   logic [DataWidth-1:0] data_q [TrsLen];
   logic [TrsLen-1:0]    h_q;
   logic [TrsLen-1:0]    v_q;
   logic [TrsLen-1:0]    f_q;
   logic [TrsLen-1:0]    eav_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '{default: FillData};
         h_q    <= '1;
         v_q    <= '1;
         f_q    <= '0;
         eav_q  <= '0;
      end else if (ce_i) begin
         data_q[0] <= data_i;
         data_q[1] <= data_q[0];
         data_q[2] <= data_q[1];
         data_q[3] <= data_q[2];
         h_q       <= {h_q[TrsLen-2:0], h_i};
         v_q       <= {v_q[TrsLen-2:0], v_i};
         f_q       <= {f_q[TrsLen-2:0], f_i};
         eav_q     <= {eav_q[TrsLen-2:0], eav_i};
      end
   end

   assign data_o   = data_q[TrsLen-1];
   assign h_o      = h_q[TrsLen-1];
   assign v_o      = v_q[TrsLen-1];
   assign f_o      = f_q[TrsLen-1];
   assign eav_o    = eav_q[TrsLen-1];
   // Newest stored sample's H, i.e. H of the previous input sample.
   assign h_last_o = h_q[0];

endmodule

// File: rtl/bt656_trs_inserter.sv
// BT.656 transmit-side TRS inserter: overwrites blanking with EAV/SAV sequences, 4-sample latency.
// Define BT656_CLIP_EN to clamp non-TRS samples out of the reserved code range.
module bt656_trs_inserter
   import bt656_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 10
) (
   input logic                  clk,
   input logic                  reset,
   bt656_trs_inserter_if.slave  vid
);

   function automatic logic [DATA_WIDTH-1:0] scale(input logic [9:0] w);
      return DATA_WIDTH'(w >> (10 - DATA_WIDTH));
   endfunction

   localparam logic [DATA_WIDTH-1:0] BlankYW = scale(BlankY);
   localparam logic [DATA_WIDTH-1:0] Pre0W   = scale(TrsPreamble0);
   localparam logic [DATA_WIDTH-1:0] Pre1W   = scale(TrsPreamble1);

   logic [DATA_WIDTH-1:0] dly_data;
   logic                  dly_h;
   logic                  dly_v;
   logic                  dly_f;
   logic                  dly_eav;
   logic                  h_last;

   logic                  eav_mark;
   logic                  sav_req;
   logic                  eav_req;
   logic                  req;
   logic                  accept;
   logic                  drop;
   logic [DATA_WIDTH-1:0] req_xyz;
   logic [DATA_WIDTH-1:0] pass_data;

   trs_state_e            state_q;
   logic [1:0]            idx_q;
   logic [DATA_WIDTH-1:0] xyz_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  valid_q;
   logic                  err_q;

   // Rising H edge: tag the sample so its EAV is emitted when it reaches the output.
   assign eav_mark = ~h_last & vid.h_in;

   bt656_sample_delay #(
      .DataWidth (DATA_WIDTH),
      .FillData  (BlankYW)
   ) u_delay (
      .clk      (clk),
      .reset    (reset),
      .ce_i     (vid.ce),
      .data_i   (vid.din),
      .h_i      (vid.h_in),
      .v_i      (vid.v_in),
      .f_i      (vid.f_in),
      .eav_i    (eav_mark),
      .data_o   (dly_data),
      .h_o      (dly_h),
      .v_o      (dly_v),
      .f_o      (dly_f),
      .eav_o    (dly_eav),
      .h_last_o (h_last)
   );

   assign sav_req = h_last & ~vid.h_in;
   assign eav_req = dly_eav & dly_h;
   assign req     = sav_req | eav_req;
   assign req_xyz = eav_req ? scale(xyz(dly_f, dly_v, 1'b1))
                            : scale(xyz(vid.f_in, vid.v_in, 1'b0));

   // A new sequence may start from idle or on the cycle the last word goes out.
   assign accept = req & ((state_q == StPass) | (idx_q == 2'd3));
   assign drop   = (req & ~accept) | (eav_req & sav_req);

`ifdef BT656_CLIP_EN
   localparam logic [DATA_WIDTH-1:0] ClipLoW = scale(ClipLo);
   localparam logic [DATA_WIDTH-1:0] ClipHiW = scale(ClipHi);

   always_comb begin
      pass_data = dly_data;
      if (dly_data < ClipLoW) begin
         pass_data = ClipLoW;
      end else if (dly_data > ClipHiW) begin
         pass_data = ClipHiW;
      end
   end
`else
   assign pass_data = dly_data;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StPass;
         idx_q   <= 2'd0;
         xyz_q   <= '0;
         dout_q  <= BlankYW;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= vid.ce;
         if (vid.ce) begin
            if (accept) begin
               state_q <= StTrs;
               idx_q   <= 2'd0;
               xyz_q   <= req_xyz;
               dout_q  <= Pre0W;
            end else begin
               unique case (state_q)
                  StPass: dout_q <= pass_data;
                  StTrs: begin
                     idx_q <= idx_q + 2'd1;
                     if (idx_q == 2'd3) begin
                        state_q <= StPass;
                        dout_q  <= pass_data;
                     end else begin
                        dout_q <= (idx_q == 2'd2) ? xyz_q : Pre1W;
                     end
                  end
               endcase
            end
            if (drop) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign vid.dout       = dout_q;
   assign vid.dout_valid = valid_q;
   assign vid.trs_err    = err_q;

endmodule

// File: tb/tb_bt656_trs_inserter.sv
// Directed bench for bt656_trs_inserter: stream-level reference plus hand-computed TRS words.
module tb_bt656_trs_inserter;

   localparam int unsigned DW = 10;

   logic clk = 1'b0;
   logic reset;

   bt656_trs_inserter_if #(.DATA_WIDTH(DW)) vid ();

   bt656_trs_inserter #(.DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .vid   (vid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference stream: inputs indexed by ce-sample number since the last reset.
   logic [9:0] m_d  [8192];
   bit         m_h  [8192];
   bit         m_v  [8192];
   bit         m_f  [8192];
   logic [9:0] dlog [8192];
   int         m_n;
   int         m_start;
   logic [9:0] m_xyz;
   bit         m_err;
   logic [9:0] m_prev;
   int         t_line;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] ref_xyz(input bit f, input bit v, input bit h);
      return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
   endfunction

   function automatic logic [9:0] clip(input logic [9:0] d);
`ifdef BT656_CLIP_EN
      if (d < 10'h004) return 10'h004;
      if (d > 10'h3FB) return 10'h3FB;
`endif
      return d;
   endfunction

   function automatic bit h_at(input int i);
      return (i < 0) ? 1'b1 : m_h[i];
   endfunction

   function automatic logic [9:0] d_at(input int i);
      return (i < 0) ? 10'h040 : m_d[i];
   endfunction

   task automatic model_reset();
      m_n     = 0;
      m_start = -100;
      m_err   = 1'b0;
      m_prev  = 10'h040;
      m_xyz   = 10'h000;
   endtask

   // Expected output for the newest sample: an EAV occupies outputs k+4..k+7 for an H rise
   // at input k, an SAV outputs k..k+3 for an H fall; a start inside a running TRS is lost.
   task automatic model_step(output logic [9:0] e);
      int t;
      bit eav_s;
      bit sav_s;
      t     = m_n - 1;
      eav_s = (t >= 4) && h_at(t - 4) && !h_at(t - 5);
      sav_s = !h_at(t) && h_at(t - 1);
      if (eav_s || sav_s) begin
         if (t < m_start + 4 || (eav_s && sav_s)) m_err = 1'b1;
         if (t >= m_start + 4) begin
            m_start = t;
            m_xyz   = eav_s ? ref_xyz(m_f[t-4], m_v[t-4], 1'b1) : ref_xyz(m_f[t], m_v[t], 1'b0);
         end
      end
      case (t - m_start)
         0:       e = 10'h3FF;
         1, 2:    e = 10'h000;
         3:       e = m_xyz;
         default: e = clip(d_at(t - 4));
      endcase
      m_prev = e;
   endtask

   task automatic drive(input bit ce_v, input logic [9:0] d, input bit h, input bit v,
                        input bit f);
      logic [9:0] e;
      vid.ce   = ce_v;
      vid.din  = d;
      vid.h_in = h;
      vid.v_in = v;
      vid.f_in = f;
      @(posedge clk);
      #1;
      check("dout_valid", 32'(vid.dout_valid), 32'(ce_v));
      if (ce_v) begin
         m_d[m_n] = d;
         m_h[m_n] = h;
         m_v[m_n] = v;
         m_f[m_n] = f;
         m_n++;
         model_step(e);
         dlog[m_n-1] = vid.dout;
         check("dout", 32'(vid.dout), 32'(e));
      end else begin
         check("dout_hold", 32'(vid.dout), 32'(m_prev));
      end
      check("trs_err", 32'(vid.trs_err), 32'(m_err));
   endtask

   task automatic idle_gap();
      drive(1'b0, 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic run_line(input int nblank, input int nact, input bit v, input bit f,
                           input bit tog, input bit extremes);
      logic [9:0] d;
      t_line = m_n;
      for (int i = 0; i < nblank; i++) begin
         d = i[0] ? 10'h040 : 10'h200;
         drive(1'b1, d, 1'b1, v, f);
         if (tog) idle_gap();
      end
      for (int i = 0; i < nact; i++) begin
         d = 10'h100 + 10'(i);
         if (extremes && i == 3) d = 10'h3FF;
         if (extremes && i == 5) d = 10'h001;
         drive(1'b1, d, 1'b0, v, f);
         if (tog) idle_gap();
      end
   endtask

   // Hand-computed words for a 16-blank line that follows an active region.
   task automatic line_checks(input logic [9:0] exyz, input logic [9:0] sxyz);
      check("eav_w0",   32'(dlog[t_line+4]),  32'h3FF);
      check("eav_w1",   32'(dlog[t_line+5]),  32'h000);
      check("eav_w2",   32'(dlog[t_line+6]),  32'h000);
      check("eav_xyz",  32'(dlog[t_line+7]),  32'(exyz));
      check("sav_w0",   32'(dlog[t_line+16]), 32'h3FF);
      check("sav_w2",   32'(dlog[t_line+18]), 32'h000);
      check("sav_xyz",  32'(dlog[t_line+19]), 32'(sxyz));
      check("active0",  32'(dlog[t_line+20]), 32'h100);
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1;
      check("rst_dout",  32'(vid.dout), 32'h040);
      check("rst_valid", 32'(vid.dout_valid), 32'h0);
      check("rst_err",   32'(vid.trs_err), 32'h0);
      #1 reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset    = 1'b1;
      vid.ce   = 1'b0;
      vid.din  = '0;
      vid.h_in = 1'b1;
      vid.v_in = 1'b1;
      vid.f_in = 1'b0;
      model_reset();
      #12;
      check("por_dout",  32'(vid.dout), 32'h040);
      check("por_valid", 32'(vid.dout_valid), 32'h0);
      check("por_err",   32'(vid.trs_err), 32'h0);
      reset = 1'b0;

      // Constant blanking: no edges, no TRS.
      for (int i = 0; i < 20; i++) drive(1'b1, 10'h040, 1'b1, 1'b1, 1'b0);

      // F=0 V=0 lines.
      run_line(16, 32, 1'b0, 1'b0, 1'b0, 1'b0);
      run_line(16, 32, 1'b0, 1'b0, 1'b0, 1'b0);
      line_checks(10'h274, 10'h200);

      // V=1, then F=1 V=1.
      run_line(16, 32, 1'b1, 1'b0, 1'b0, 1'b0);
      line_checks(10'h2D8, 10'h2AC);
      run_line(16, 32, 1'b1, 1'b1, 1'b0, 1'b0);
      line_checks(10'h3C4, 10'h3B0);

      // Short blanking: EAV intact, SAV lost, sticky error.
      run_line(5, 32, 1'b0, 1'b0, 1'b0, 1'b0);
      check("short_eav0",  32'(dlog[t_line+4]), 32'h3FF);
      check("short_eav3",  32'(dlog[t_line+7]), 32'h274);
      check("short_blank", 32'(dlog[t_line+8]), 32'h200);
      check("short_act0",  32'(dlog[t_line+9]), 32'h100);
      check("err_set",     32'(vid.trs_err), 32'h1);
      run_line(16, 32, 1'b0, 1'b0, 1'b0, 1'b0);
      line_checks(10'h274, 10'h200);
      check("err_sticky",  32'(vid.trs_err), 32'h1);

      // ce toggling every cycle.
      pulse_reset();
      for (int i = 0; i < 6; i++) drive(1'b1, 10'h040, 1'b1, 1'b0, 1'b0);
      run_line(16, 32, 1'b0, 1'b0, 1'b1, 1'b0);
      run_line(16, 32, 1'b0, 1'b0, 1'b1, 1'b0);
      line_checks(10'h274, 10'h200);

      // Reserved codes in the active region.
      run_line(16, 32, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef BT656_CLIP_EN
      check("clip_hi", 32'(dlog[t_line+23]), 32'h3FB);
      check("clip_lo", 32'(dlog[t_line+25]), 32'h004);
`else
      check("clip_hi", 32'(dlog[t_line+23]), 32'h3FF);
      check("clip_lo", 32'(dlog[t_line+25]), 32'h001);
`endif

      // Reset while the EAV is on its second zero word.
      t_line = m_n;
      for (int i = 0; i < 7; i++) drive(1'b1, 10'h200, 1'b1, 1'b0, 1'b0);
      check("mid_w0", 32'(dlog[t_line+4]), 32'h3FF);
      check("mid_w2", 32'(dlog[t_line+6]), 32'h000);
      pulse_reset();
      for (int i = 0; i < 10; i++) drive(1'b1, i[0] ? 10'h040 : 10'h200, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
